pipeline_hazard_ctrl: RTL

//  Central stall/flush sequencer for the 5-stage pipeline; sits beside the EX forwarding unit.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 30 +++
 rtl/pipeline_hazard_ctrl_if.sv | 52 +++++
 rtl/pipeline_hazard_ctrl_sat_counter.sv | 35 +++
 rtl/pipeline_hazard_ctrl.sv | 128 ++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//  - hz_state_e : sequencer state encoding (RUN / MDU_WAIT)
//  - OP_*       : RV32 major opcodes used by ID decode to form id_use_rs1/id_use_rs2
//  - op_uses_rs1/op_uses_rs2 : decode helpers producing those use flags
package pipeline_hazard_ctrl_pkg;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MDU_WAIT = 1'b1
    } hz_state_e;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    // U-type and JAL carry no rs1 field; everything else reads rs1.
    function automatic logic op_uses_rs1(input logic [6:0] op);
        return !((op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL));
    endfunction

    // Only R-type, branches and stores read rs2.
    function automatic logic op_uses_rs2(input logic [6:0] op);
        return (op == OP_OP) || (op == OP_BRANCH) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the pipeline and the hazard controller.
//  Pipeline-side (master) drives: ID source regs/use flags, EX load/rd info,
//  redirect, MDU start/done, data-memory request/ready.
//  Controller-side (slave) drives: per-stage stall/flush enables, mdu_busy,
//  mdu_timeout, stall_cycles perf counter and dbg_state.
// Handshake semantics: dmem_req/dmem_ready behave as valid/ready -- an access
// completes only in a cycle where both are high; req high with ready low is a
// wait state and the pipe is frozen. ex_mdu_start is accepted in the cycle it
// is seen; mdu_done is a single-cycle completion pulse.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic             id_ex_memread;
    logic [4:0]       id_ex_rd;
    logic             ex_redirect;
    logic             ex_mdu_start;
    logic             mdu_done;
    logic             dmem_req;
    logic             dmem_ready;

    logic             pc_stall;
    logic             if_id_stall;
    logic             if_id_flush;
    logic             id_ex_stall;
    logic             id_ex_flush;
    logic             ex_mem_stall;
    logic             mem_wb_flush;
    logic             mdu_busy;
    logic             mdu_timeout;
    logic [CNT_W-1:0] stall_cycles;
    pipeline_hazard_ctrl_pkg::hz_state_e dbg_state;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_ex_memread, id_ex_rd,
               ex_redirect, ex_mdu_start, mdu_done, dmem_req, dmem_ready,
        input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
               ex_mem_stall, mem_wb_flush, mdu_busy, mdu_timeout, stall_cycles,
               dbg_state
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_ex_memread, id_ex_rd,
               ex_redirect, ex_mdu_start, mdu_done, dmem_req, dmem_ready,
        output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
               ex_mem_stall, mem_wb_flush, mdu_busy, mdu_timeout, stall_cycles,
               dbg_state
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
//  clk, rst_n : clock, asynchronous active-low reset (count -> 0)
//  inc        : add one this cycle (ignored once at all-ones)
//  clr        : synchronous clear, wins over inc
//  count      : current value
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Resolves what forwarding cannot: load-use bubbles, taken-branch/jump
// flushes, multi-cycle MUL/DIV occupancy and data-memory wait states.
//  clk, rst_n : clock, asynchronous active-low reset
//  hz (slave) : pipeline inputs in, per-stage stall/flush enables out,
//               mdu_busy, sticky mdu_timeout, stall_cycles, dbg_state
// Priority (highest first): memory wait, MDU busy, redirect, MDU start,
// load-use.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MDU_MAX_LAT = 34
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pipeline_hazard_ctrl_if.slave  hz
);
    localparam int MCW = $clog2(MDU_MAX_LAT + 1);

    hz_state_e  state_q, state_d;
    logic       mdu_timeout_q, mdu_timeout_d;

    logic       load_use;
    logic       mem_wait;
    logic       mdu_wait_inc;
    logic       mdu_enter;
    logic       pc_stall, if_id_stall, if_id_flush;
    logic       id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush;
    logic       pc_stall_o;
    logic [MCW-1:0]   mdu_cnt;
    logic [CNT_W-1:0] stall_cnt;

    assign load_use = hz.id_ex_memread && (hz.id_ex_rd != 5'd0) &&
                      ((hz.id_use_rs1 && (hz.id_rs1 == hz.id_ex_rd)) ||
                       (hz.id_use_rs2 && (hz.id_rs2 == hz.id_ex_rd)));
    assign mem_wait = hz.dmem_req && !hz.dmem_ready;

    always_comb begin
        state_d      = state_q;
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        mem_wb_flush = 1'b0;

        // mdu_done is a one-shot pulse, so it retires the wait even while the
        // memory is stalling; otherwise the FSM would never leave MDU_WAIT.
        if ((state_q == ST_MDU_WAIT) && hz.mdu_done) begin
            state_d = ST_RUN;
        end

        if (mem_wait || ((state_q == ST_MDU_WAIT) && !hz.mdu_done)) begin
            // Freeze everything up to EX/MEM; MEM/WB gets a bubble.
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (hz.ex_redirect) begin
            // Wrong-path IF/ID and ID/EX are squashed; a pending load-use in
            // ID is discarded along with them.
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
        end else if (hz.ex_mdu_start && !hz.mdu_done) begin
            // A 1-cycle op (done with start) never enters MDU_WAIT.
            state_d      = ST_MDU_WAIT;
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (load_use) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_flush  = 1'b1;
        end
    end

    assign mdu_enter     = (state_q == ST_RUN) && (state_d == ST_MDU_WAIT);
    assign mdu_wait_inc  = (state_q == ST_MDU_WAIT) && !hz.mdu_done;
    // Flag raised by the wait cycle that brings the count to MDU_MAX_LAT.
    assign mdu_timeout_d = mdu_timeout_q ||
                           (mdu_wait_inc && (mdu_cnt == MCW'(MDU_MAX_LAT - 1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            mdu_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            mdu_timeout_q <= mdu_timeout_d;
        end
    end

    sat_counter #(.CNT_W(MCW)) u_mdu_lat (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (mdu_wait_inc),
        .clr   (mdu_enter),
        .count (mdu_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (pc_stall_o),
        .clr   (1'b0),
        .count (stall_cnt)
    );

    // Controls are combinational from inputs; gating with rst_n makes every
    // output drop the instant reset asserts, even with stall-causing inputs.
    assign pc_stall_o      = rst_n && pc_stall;
    assign hz.pc_stall     = pc_stall_o;
    assign hz.if_id_stall  = rst_n && if_id_stall;
    assign hz.if_id_flush  = rst_n && if_id_flush;
    assign hz.id_ex_stall  = rst_n && id_ex_stall;
    assign hz.id_ex_flush  = rst_n && id_ex_flush;
    assign hz.ex_mem_stall = rst_n && ex_mem_stall;
    assign hz.mem_wb_flush = rst_n && mem_wb_flush;
    assign hz.mdu_busy     = (state_q == ST_MDU_WAIT);
    assign hz.mdu_timeout  = mdu_timeout_q;
    assign hz.stall_cycles = stall_cnt;
    assign hz.dbg_state    = state_q;
endmodule
